// File: rtl/stopwatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_pkg
// Shared constants for the stopwatch: sequencer state encodings, default rate
// constants, the blank-digit cathode pattern used by the display path, and a
// helper that sizes divider counters.
// -----------------------------------------------------------------------------
package stopwatch_ctrl_pkg;

    // Sequencer states (kept as plain 2-bit constants for legacy consumers).
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_PAUSE = 2'd1;
    localparam logic [1:0] S_ADJ   = 2'd2;

    // Default rates for the production build.
    localparam int unsigned DEF_CLK_HZ          = 100_000_000;
    localparam int unsigned DEF_COUNT_HZ        = 1;
    localparam int unsigned DEF_ADJ_HZ          = 2;
    localparam int unsigned DEF_SCAN_HZ         = 500;
    localparam int unsigned DEF_BLINK_HZ        = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;

    // Active-low segment cathodes: all high blanks the digit.
    localparam logic [6:0] SEG_OFF = 7'b111_1111;

    // Counter width for a divide-by-n counter holding 0..n-1.
    function automatic int unsigned div_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer, level debouncer and rising-edge pulse for one raw
// push button.
//
// Configuration macro: STOPWATCH_DEBOUNCE_EN
//   defined   : the accepted level follows the synchronized input only after it
//               has differed for DEBOUNCE_CYCLES consecutive cycles; press_o
//               fires DEBOUNCE_CYCLES+1 cycles after the synchronized rise.
//   undefined : accepted level = synchronized level; press_o fires one cycle
//               after the synchronized rise.
//
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   btn_i   in  raw asynchronous button, active-high
//   press_o out one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module btn_debounce
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [1:0] sync_q;
    logic       level_cur;   // accepted (debounced) button level
    logic       level_q;     // accepted level one cycle late, for edge detect
    logic       press_q;

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int unsigned     CNT_W    = div_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;

    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        // Any cycle where the input agrees with the accepted level restarts
        // the run, so a bounce never accumulates toward a change.
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign level_cur = deb_q;
`else
    assign level_cur = sync_q[1];
`endif

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_cur;
            press_q <= level_cur & ~level_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Central stopwatch sequencer: conditions the buttons and switches, runs the
// RUN/PAUSE/ADJUST state machine and produces every rate enable the datapath
// and display multiplexer use. All outputs come straight from flops.
//
// Configuration macro: STOPWATCH_DEBOUNCE_EN (button debounce, see btn_debounce)
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   btn_pause/btn_reset raw buttons, active-high
//   sw_sel              raw switch, 0 = minutes, 1 = seconds
//   sw_adj              raw switch, 1 = adjust mode
//   count_tick          pulse: advance time one second
//   count_clr           pulse: clear all digits to 00:00
//   adj_tick            pulse: increment the selected field
//   adj_mode            adjust mode active
//   adj_field           synchronized sel
//   blink               blink level, 1 = digit visible
//   scan_en             pulse: display mux advances one digit
//   running             saved run flag
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
    parameter int unsigned COUNT_HZ        = DEF_COUNT_HZ,
    parameter int unsigned ADJ_HZ          = DEF_ADJ_HZ,
    parameter int unsigned SCAN_HZ         = DEF_SCAN_HZ,
    parameter int unsigned BLINK_HZ        = DEF_BLINK_HZ,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_pause,
    input  logic btn_reset,
    input  logic sw_sel,
    input  logic sw_adj,
    output logic count_tick,
    output logic count_clr,
    output logic adj_tick,
    output logic adj_mode,
    output logic adj_field,
    output logic blink,
    output logic scan_en,
    output logic running
);

    localparam int unsigned COUNT_N = CLK_HZ / COUNT_HZ;
    localparam int unsigned ADJ_N   = CLK_HZ / ADJ_HZ;
    localparam int unsigned SCAN_N  = CLK_HZ / SCAN_HZ;
    localparam int unsigned BLINK_N = CLK_HZ / (2 * BLINK_HZ);

    localparam int unsigned COUNT_W = div_width(COUNT_N);
    localparam int unsigned ADJ_W   = div_width(ADJ_N);
    localparam int unsigned SCAN_W  = div_width(SCAN_N);
    localparam int unsigned BLINK_W = div_width(BLINK_N);

    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(COUNT_N - 1);
    localparam logic [ADJ_W-1:0]   ADJ_LAST   = ADJ_W'(ADJ_N - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_N - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_N - 1);

    if (COUNT_N < 2 || ADJ_N < 2 || SCAN_N < 2 || BLINK_N < 2) begin : g_bad_rate
        $error("stopwatch_ctrl: every divider ratio must be at least 2");
    end

    // ---------------- input conditioning ----------------
    logic pause_press, reset_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_pause),
        .press_o (pause_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_reset),
        .press_o (reset_press)
    );

    logic [1:0] sel_sync_q, adj_sync_q;
    logic       adj_sync;
    assign adj_sync = adj_sync_q[1];

    // ---------------- state ----------------
    logic [1:0]         state_q, state_d;
    logic               run_q, run_d;
    logic [COUNT_W-1:0] count_div_q, count_div_d;
    logic [ADJ_W-1:0]   adj_div_q, adj_div_d;
    logic [SCAN_W-1:0]  scan_div_q, scan_div_d;
    logic [BLINK_W-1:0] blink_div_q, blink_div_d;
    logic               count_tick_q, count_clr_q, adj_tick_q, scan_en_q;
    logic               adj_mode_q, blink_q;
    logic               count_wrap, adj_wrap, scan_wrap, blink_wrap;

    assign count_wrap = (state_q == S_RUN) && (count_div_q == COUNT_LAST);
    assign adj_wrap   = (state_q == S_ADJ) && (adj_div_q == ADJ_LAST);
    assign scan_wrap  = (scan_div_q == SCAN_LAST);
    assign blink_wrap = (blink_div_q == BLINK_LAST);

    // Transitions in priority order: reset press swallows the whole cycle
    // (including a simultaneous pause press); the adjust switch beats pause.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (reset_press) begin
            state_d = state_q;
        end else if (adj_sync && state_q != S_ADJ) begin
            state_d = S_ADJ;
        end else if (!adj_sync && state_q == S_ADJ) begin
            state_d = run_q ? S_RUN : S_PAUSE;
        end else if (pause_press) begin
            run_d = !run_q;
            if (state_q != S_ADJ) begin
                state_d = run_d ? S_RUN : S_PAUSE;
            end
        end
    end

    always_comb begin
        // Count divider holds outside RUN so a resume continues mid-second.
        count_div_d = count_div_q;
        if (reset_press || count_wrap) begin
            count_div_d = '0;
        end else if (state_q == S_RUN) begin
            count_div_d = count_div_q + COUNT_W'(1);
        end
        // Adjust divider sits at zero outside ADJ, so the first adj_tick lands
        // a full period after entry.
        adj_div_d   = (state_q != S_ADJ || adj_wrap) ? '0 : adj_div_q + ADJ_W'(1);
        scan_div_d  = scan_wrap  ? '0 : scan_div_q + SCAN_W'(1);
        blink_div_d = blink_wrap ? '0 : blink_div_q + BLINK_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_sync_q   <= 2'b00;
            adj_sync_q   <= 2'b00;
            state_q      <= S_PAUSE;
            run_q        <= 1'b0;
            count_div_q  <= '0;
            adj_div_q    <= '0;
            scan_div_q   <= '0;
            blink_div_q  <= '0;
            count_tick_q <= 1'b0;
            count_clr_q  <= 1'b0;
            adj_tick_q   <= 1'b0;
            scan_en_q    <= 1'b0;
            adj_mode_q   <= 1'b0;
            blink_q      <= 1'b1;
        end else begin
            sel_sync_q   <= {sel_sync_q[0], sw_sel};
            adj_sync_q   <= {adj_sync_q[0], sw_adj};
            state_q      <= state_d;
            run_q        <= run_d;
            count_div_q  <= count_div_d;
            adj_div_q    <= adj_div_d;
            scan_div_q   <= scan_div_d;
            blink_div_q  <= blink_div_d;
            count_tick_q <= count_wrap && !reset_press;
            count_clr_q  <= reset_press;
            adj_tick_q   <= adj_wrap;
            scan_en_q    <= scan_wrap;
            adj_mode_q   <= (state_d == S_ADJ);
            blink_q      <= blink_wrap ? ~blink_q : blink_q;
        end
    end

    assign count_tick = count_tick_q;
    assign count_clr  = count_clr_q;
    assign adj_tick   = adj_tick_q;
    assign adj_mode   = adj_mode_q;
    assign adj_field  = sel_sync_q[1];
    assign blink      = blink_q;
    assign scan_en    = scan_en_q;
    assign running    = run_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl. Pulse outputs (count_tick, count_clr,
// adj_tick) are checked by a scoreboard: stimulus pushes the expected pulse
// kind and cycle, a monitor pops on every observed pulse. Levels are checked
// directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;
    import stopwatch_ctrl_pkg::*;

    localparam int COUNT_N = 1000;  // 1000 Hz / 1 Hz
    localparam int ADJ_N   = 500;   // 1000 Hz / 2 Hz
    localparam int SCAN_N  = 4;     // 1000 Hz / 250 Hz
    localparam int BLINK_N = 250;   // 1000 Hz / (2*2 Hz)
    localparam int DEB     = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
    // Raw edge -> press pulse: 2 synchronizer flops + DEB + 1.
    localparam int LAT    = DEB + 3;
    localparam bit BOUNCE = 1'b1;
`else
    localparam int LAT    = 3;
    localparam bit BOUNCE = 1'b0;
`endif

    localparam logic [2:0] EV_TICK = 3'b001;
    localparam logic [2:0] EV_CLR  = 3'b010;
    localparam logic [2:0] EV_ADJ  = 3'b100;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n, btn_pause, btn_reset, sw_sel, sw_adj;
    logic count_tick, count_clr, adj_tick, adj_mode, adj_field, blink, scan_en, running;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    ev_t sb_q[$];

    stopwatch_ctrl #(
        .CLK_HZ          (1000),
        .COUNT_HZ        (1),
        .ADJ_HZ          (2),
        .SCAN_HZ         (250),
        .BLINK_HZ        (2),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_pause  (btn_pause),
        .btn_reset  (btn_reset),
        .sw_sel     (sw_sel),
        .sw_adj     (sw_adj),
        .count_tick (count_tick),
        .count_clr  (count_clr),
        .adj_tick   (adj_tick),
        .adj_mode   (adj_mode),
        .adj_field  (adj_field),
        .blink      (blink),
        .scan_en    (scan_en),
        .running    (running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input logic [2:0] kind, input int at);
        ev_t ev;
        ev.kind = kind;
        ev.cyc  = at;
        sb_q.push_back(ev);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count_tick"}, 32'(count_tick), 0);
        check({tag, "_count_clr"},  32'(count_clr), 0);
        check({tag, "_adj_tick"},   32'(adj_tick), 0);
        check({tag, "_scan_en"},    32'(scan_en), 0);
        check({tag, "_adj_mode"},   32'(adj_mode), 0);
        check({tag, "_adj_field"},  32'(adj_field), 0);
        check({tag, "_blink"},      32'(blink), 1);
        check({tag, "_running"},    32'(running), 0);
        check({tag, "_state"},      32'(dut.state_q), 32'(S_PAUSE));
    endtask

    // Scoreboard monitor: every observed pulse must match the next expectation.
    initial begin : monitor
        ev_t        ev;
        logic [2:0] seen;
        forever begin
            @(negedge clk);
            if (count_tick || count_clr || adj_tick) begin
                seen = {adj_tick, count_clr, count_tick};
                check("tick_adj_exclusive", 32'(count_tick & adj_tick), 0);
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_event", 32'(seen), 0);
                end else begin
                    ev = sb_q.pop_front();
                    check("sb_event_kind", 32'(seen), 32'(ev.kind));
                    check("sb_event_cycle", cyc, ev.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   r0, c, s, q, q2, s2, b, p3, h3, q4, s4, a, h4, e, t4, f, g, r1;
        int   scan_cnt, scan_bad, last_scan, blink_tog, blink_bad, drops;
        logic blink_prev;

        rst_n = 1'b0; btn_pause = 1'b0; btn_reset = 1'b0; sw_sel = 1'b0; sw_adj = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        r0 = cyc;

        // 1. Idle after reset: paused, scan every 4, blink every 250 from 1.
        scan_cnt = 0; scan_bad = 0; last_scan = r0;
        blink_tog = 0; blink_bad = 0; blink_prev = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            if (scan_en) begin
                if (cyc - last_scan != SCAN_N) scan_bad++;
                last_scan = cyc;
                scan_cnt++;
            end
            if (blink != blink_prev) begin
                if ((cyc - r0) % BLINK_N != 0) blink_bad++;
                blink_tog++;
                blink_prev = blink;
            end
        end
        check("scan_period_errors", scan_bad, 0);
        check("scan_pulse_count", scan_cnt, 3000 / SCAN_N);
        check("blink_toggle_errors", blink_bad, 0);
        check("blink_toggle_count", blink_tog, 3000 / BLINK_N);
        check("idle_running", 32'(running), 0);
        check("idle_state", 32'(dut.state_q), 32'(S_PAUSE));

        // 2. Start, tick at +1000, pause at +1500 (divider 500), resume.
        c = cyc; btn_pause = 1'b1; s = c + LAT + 1;
        expect_ev(EV_TICK, s + COUNT_N);
        wait_until(s - 1); check("start_latency_before", 32'(running), 0);
        wait_until(s);     check("start_latency_after", 32'(running), 1);
        check("start_state", 32'(dut.state_q), 32'(S_RUN));
        wait_until(c + 10); btn_pause = 1'b0;
        wait_until(s + 50); check("single_press_one_toggle", 32'(running), 1);
        q = s + 1499 - LAT;
        wait_until(q); btn_pause = 1'b1;
        wait_until(s + 1499); check("pause_before", 32'(running), 1);
        wait_until(s + 1500); check("pause_after", 32'(running), 0);
        wait_until(q + 10); btn_pause = 1'b0;
        wait_until(s + 1800);
        q2 = cyc; btn_pause = 1'b1; s2 = q2 + LAT + 1;
        expect_ev(EV_TICK, s2 + COUNT_N - 500);
        wait_until(s2); check("resume_running", 32'(running), 1);
        wait_until(q2 + 10); btn_pause = 1'b0;

        // 3. Bounce for 20 cycles, then settle high: exactly one pause.
        b = s2 + 600;
        wait_until(b);
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            btn_pause = BOUNCE && ((i / 2) % 2 == 0);
            @(negedge clk);
            if (!running) drops++;
        end
        check("bounce_ignored", drops, 0);
        btn_pause = 1'b1;
        p3 = b + 20 + LAT + 1;
        h3 = p3 - (s2 + 500);
        wait_until(p3 - 1); check("settle_before", 32'(running), 1);
        wait_until(p3);     check("settle_after", 32'(running), 0);
        wait_until(b + 30); btn_pause = 1'b0;

        // 4. Adjust while running: count held, adj_tick every 500, return.
        q4 = p3 + 50;
        wait_until(q4); btn_pause = 1'b1; s4 = q4 + LAT + 1;
        wait_until(s4); check("adj_pre_running", 32'(running), 1);
        wait_until(q4 + 10); btn_pause = 1'b0;
        a = s4 + 50;
        wait_until(a); sw_adj = 1'b1; sw_sel = 1'b0;
        expect_ev(EV_ADJ, a + 3 + ADJ_N);
        expect_ev(EV_ADJ, a + 3 + 2 * ADJ_N);
        h4 = h3 + (a + 3 - s4);
        wait_until(a + 2); check("adj_mode_before", 32'(adj_mode), 0);
        wait_until(a + 3); check("adj_mode_after", 32'(adj_mode), 1);
        check("adj_field_min", 32'(adj_field), 0);
        check("adj_run_saved", 32'(running), 1);
        check("adj_state", 32'(dut.state_q), 32'(S_ADJ));
        wait_until(a + 600); sw_sel = 1'b1;
        wait_until(a + 601); check("adj_field_sync_before", 32'(adj_field), 0);
        wait_until(a + 602); check("adj_field_sync_after", 32'(adj_field), 1);
        wait_until(a + 700); sw_sel = 1'b0;
        e = a + 1100;
        t4 = e + 3 + COUNT_N - h4;
        expect_ev(EV_TICK, t4);
        wait_until(e); sw_adj = 1'b0;
        wait_until(e + 3);
        check("adj_exit_mode", 32'(adj_mode), 0);
        check("adj_exit_state", 32'(dut.state_q), 32'(S_RUN));

        // 5. Reset and pause pressed together: clear wins, run flag kept.
        f = t4 + 50;
        wait_until(f); btn_pause = 1'b1; btn_reset = 1'b1;
        expect_ev(EV_CLR, f + LAT + 1);
        expect_ev(EV_TICK, f + LAT + 1 + COUNT_N);
        wait_until(f + LAT + 2);
        check("clr_keeps_running", 32'(running), 1);
        check("clr_keeps_state", 32'(dut.state_q), 32'(S_RUN));
        wait_until(f + 10); btn_pause = 1'b0; btn_reset = 1'b0;

        // 6. Asynchronous reset in the middle of adjust.
        g = f + LAT + 1 + COUNT_N + 20;
        wait_until(g); sw_adj = 1'b1;
        wait_until(g + 3); check("pre_reset_adj_mode", 32'(adj_mode), 1);
        wait_until(g + 200);
        sw_adj = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        @(negedge clk);
        rst_n = 1'b1;
        r1 = cyc;
        wait_until(r1 + 3); check("post_reset_scan_before", 32'(scan_en), 0);
        wait_until(r1 + 4); check("post_reset_scan_after", 32'(scan_en), 1);
        wait_until(r1 + 1200);
        check("post_reset_running", 32'(running), 0);
        check("post_reset_state", 32'(dut.state_q), 32'(S_PAUSE));

        check("sb_leftover", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
